// File: rtl/gnrl_sync_fifo.sv
// gnrl_sync_fifo: single-clock valid/ready FIFO used between pipeline stages.
// Output data is always read from storage, so the data path is cut between
// writer and reader (no fall-through when empty, no pass-through when full).
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   flush        synchronous clear of pointers and count; same-cycle push/pop dropped
//   i_valid      writer presents i_data
//   i_ready      FIFO can accept (not full); push = i_valid & i_ready
//   i_data       write data
//   o_valid      head entry valid (not empty); pop = o_valid & o_ready
//   o_ready      reader accepts head entry
//   o_data       head entry data (don't-care while o_valid = 0)
//   count        occupied entries, 0..DEPTH
module gnrl_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [AW:0]      count
);

  localparam int unsigned PTR_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;

  // Status derived only from registered pointers; MSB is the wrap bit.
  assign wr_idx  = wr_ptr[AW-1:0];
  assign rd_idx  = rd_ptr[AW-1:0];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);
  assign i_ready = !full;
  assign o_valid = !empty;
  assign o_data  = mem[rd_idx];
  assign push    = i_valid && !full;
  assign pop     = o_ready && !empty;

  // Storage: load-enable flops without reset; a flushed push is not stored.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_idx] <= i_data;
    end
  end

  // Control state: pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + PTR_W'(1);
        2'b01:   count <= count - PTR_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_gnrl_sync_fifo.sv
// Self-checking bench for gnrl_sync_fifo: directed scenarios plus randomized
// valid/ready traffic, checked by a queue-based reference model in a monitor.
module tb_gnrl_sync_fifo;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             i_valid;
  logic             i_ready;
  logic [WIDTH-1:0] i_data;
  logic             o_valid;
  logic             o_ready;
  logic [WIDTH-1:0] o_data;
  logic [AW:0]      count;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] model_q[$];

  gnrl_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs for one clock edge; returns 1 time unit after that edge.
  task automatic step(input logic iv, input logic [WIDTH-1:0] d,
                      input logic ordy, input logic fl);
    i_valid = iv;
    i_data  = d;
    o_ready = ordy;
    flush   = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < DEPTH + 1; k++) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  // Monitor / reference model: sampled mid-cycle, predicts the next edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_q.delete();
      chk("rst_o_valid", 64'(o_valid), 64'(1'b0));
      chk("rst_i_ready", 64'(i_ready), 64'(1'b1));
      chk("rst_count", 64'(count), 64'(0));
    end else begin
      int unsigned sz;
      logic m_push;
      logic m_pop;
      logic [WIDTH-1:0] exp_d;
      sz = model_q.size();
      chk("mon_count", 64'(count), 64'(sz));
      chk("mon_o_valid", 64'(o_valid), 64'(sz != 0));
      chk("mon_i_ready", 64'(i_ready), 64'(sz < DEPTH));
      m_push = i_valid && (sz < DEPTH);
      m_pop  = o_ready && (sz != 0);
      if (flush) begin
        model_q.delete();
      end else begin
        if (m_pop) begin
          exp_d = model_q.pop_front();
          chk("mon_pop_data", 64'(o_data), 64'(exp_d));
        end
        if (m_push) model_q.push_back(i_data);
      end
    end
  end

  logic [WIDTH-1:0] fill_vals [4];

  initial begin
    rst_n   = 1'b0;
    flush   = 1'b0;
    i_valid = 1'b0;
    o_ready = 1'b0;
    i_data  = '0;
    fill_vals[0] = 32'h11; fill_vals[1] = 32'h22;
    fill_vals[2] = 32'h33; fill_vals[3] = 32'h44;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("post_rst_count", 64'(count), 64'(0));
    chk("post_rst_i_ready", 64'(i_ready), 64'(1));

    // Asynchronous reset mid-stream at count=3.
    for (int k = 0; k < 3; k++) step(1'b1, WIDTH'(32'hA0 + k), 1'b0, 1'b0);
    chk("pre_rst_count3", 64'(count), 64'(3));
    i_valid = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk("async_rst_count", 64'(count), 64'(0));
    chk("async_rst_o_valid", 64'(o_valid), 64'(0));
    chk("async_rst_i_ready", 64'(i_ready), 64'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 32'h77, 1'b0, 1'b0);
    chk("first_after_rst", 64'(o_data), 64'(32'h77));
    drain();

    // Fill, refused fifth push, drain in order.
    for (int k = 0; k < 4; k++) step(1'b1, fill_vals[k], 1'b0, 1'b0);
    chk("fill_count", 64'(count), 64'(4));
    chk("fill_i_ready", 64'(i_ready), 64'(0));
    step(1'b1, 32'h55, 1'b0, 1'b0);
    chk("fifth_refused_count", 64'(count), 64'(4));
    for (int k = 0; k < 4; k++) begin
      chk("drain_data", 64'(o_data), 64'(fill_vals[k]));
      step(1'b0, '0, 1'b1, 1'b0);
    end
    chk("drain_o_valid", 64'(o_valid), 64'(0));
    chk("drain_count", 64'(count), 64'(0));

    // Push+pop at full: only the pop happens, then steady push+pop at 3.
    for (int k = 0; k < 4; k++) step(1'b1, WIDTH'(32'h60 + k), 1'b0, 1'b0);
    step(1'b1, 32'h66, 1'b1, 1'b0);
    chk("full_pp_count", 64'(count), 64'(3));
    chk("full_pp_i_ready", 64'(i_ready), 64'(1));
    step(1'b1, 32'h66, 1'b1, 1'b0);
    chk("steady_pp_count", 64'(count), 64'(3));
    chk("steady_pp_head", 64'(o_data), 64'(32'h62));
    drain();

    // Wrap-around: count held at 1 while 10 values stream through.
    step(1'b1, 32'h0, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, WIDTH'(k), 1'b1, 1'b0);
      chk("wrap_count", 64'(count), 64'(1));
      chk("wrap_head", 64'(o_data), 64'(k));
    end
    drain();

    // Flush collides with push and pop.
    step(1'b1, 32'hC1, 1'b0, 1'b0);
    step(1'b1, 32'hC2, 1'b0, 1'b0);
    step(1'b1, 32'hAA, 1'b1, 1'b1);
    chk("flush_count", 64'(count), 64'(0));
    chk("flush_o_valid", 64'(o_valid), 64'(0));
    chk("flush_i_ready", 64'(i_ready), 64'(1));
    step(1'b1, 32'hBB, 1'b0, 1'b0);
    chk("post_flush_data", 64'(o_data), 64'(32'hBB));
    chk("post_flush_count", 64'(count), 64'(1));
    drain();

    // Randomized traffic with occasional flush.
    for (int k = 0; k < 10000; k++) begin
      step(1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 63) == 0));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
